// File: rtl/rc4_encryptor.sv
// rc4_encryptor: RC4 KSA+PRGA over a shared S memory, XORs keystream with plaintext ROM into ciphertext RAM.
module rc4_encryptor #(
    parameter int MSG_LEN   = 32,
    parameter int KEY_BYTES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [8*KEY_BYTES-1:0]   secret_key,
    output logic [7:0]               s_address,
    output logic [7:0]               s_data,
    output logic                     s_wren,
    input  logic [7:0]               s_q,
    output logic [7:0]               p_address,
    input  logic [7:0]               p_q,
    output logic [7:0]               c_address,
    output logic [7:0]               c_data,
    output logic                     c_wren,
    output logic                     busy,
    output logic                     done
);
    localparam int KW = 8 * KEY_BYTES;
    localparam logic [7:0] LAST = 8'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, INIT, INC, RD_I, WT_I, LD_I, RD_J, WT_J, LD_J,
        WR_I, WR_J, RD_F, WT_F, WR_C, DONE
    } state_t;

    state_t state, next;
    logic prga;
    logic [7:0] i, j, k, si, sj;
    logic [KW-1:0] key_r;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = start ? INIT : state;
            INIT:       next = (i == 8'hff) ? RD_I : INIT;
            INC:        next = RD_I;
            RD_I:       next = WT_I;
            WT_I:       next = LD_I;
            LD_I:       next = RD_J;
            RD_J:       next = WT_J;
            WT_J:       next = LD_J;
            LD_J:       next = WR_I;
            WR_I:       next = WR_J;
            WR_J:       next = prga ? RD_F : ((i == 8'hff) ? INC : RD_I);
            RD_F:       next = WT_F;
            WT_F:       next = WR_C;
            WR_C:       next = (k == LAST) ? DONE : INC;
            default:    next = IDLE;
        endcase
    end

    // key_r rotates one byte per KSA step so its top byte is always key[i mod KEY_BYTES]
    always_ff @(posedge clk) begin
        if (!reset) begin
            prga  <= 1'b0;
            i     <= 8'h00;
            j     <= 8'h00;
            k     <= 8'h00;
            si    <= 8'h00;
            sj    <= 8'h00;
            key_r <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    key_r <= secret_key;
                    prga  <= 1'b0;
                    i     <= 8'h00;
                    j     <= 8'h00;
                    k     <= 8'h00;
                end
                INIT, INC: i <= i + 8'h01;
                LD_I: begin
                    si <= s_q;
                    j  <= j + s_q + (prga ? 8'h00 : key_r[KW-1 -: 8]);
                end
                LD_J: sj <= s_q;
                WR_J: if (!prga) begin
                    i     <= i + 8'h01;
                    key_r <= KW'({key_r, key_r[KW-1 -: 8]});
                    if (i == 8'hff) begin
                        prga <= 1'b1;
                        j    <= 8'h00;
                        k    <= 8'h00;
                    end
                end
                WR_C: if (k != LAST) k <= k + 8'h01;
                default: ;
            endcase
        end
    end

    always_comb begin
        s_address = 8'h00;
        s_data    = 8'h00;
        s_wren    = 1'b0;
        p_address = 8'h00;
        c_address = 8'h00;
        c_data    = 8'h00;
        c_wren    = 1'b0;
        busy      = state != IDLE && state != DONE;
        done      = state == DONE;
        case (state)
            INIT: begin
                s_address = i;
                s_data    = i;
                s_wren    = 1'b1;
            end
            RD_I, WT_I: s_address = i;
            RD_J, WT_J: s_address = j;
            WR_I: begin
                s_address = i;
                s_data    = sj;
                s_wren    = 1'b1;
            end
            WR_J: begin
                s_address = j;
                s_data    = si;
                s_wren    = 1'b1;
            end
            RD_F, WT_F: begin
                s_address = si + sj;
                p_address = k;
            end
            WR_C: begin
                c_address = k;
                c_data    = s_q ^ p_q;
                c_wren    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rc4_encryptor.sv
// tb_rc4_encryptor: two instances (9-byte and 256-byte messages) on behavioural memories with two-cycle read latency.
module tb_rc4_encryptor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic [23:0] secret_key = 24'h0;
    always #5 clk = ~clk;

    logic [7:0] s_address_a, s_data_a, s_q_a, p_address_a, p_q_a, c_address_a, c_data_a;
    logic [7:0] s_address_b, s_data_b, s_q_b, p_address_b, p_q_b, c_address_b, c_data_b;
    logic s_wren_a, c_wren_a, busy_a, done_a, s_wren_b, c_wren_b, busy_b, done_b;

    rc4_encryptor #(.MSG_LEN(9)) dut_a (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .s_address(s_address_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
        .p_address(p_address_a), .p_q(p_q_a),
        .c_address(c_address_a), .c_data(c_data_a), .c_wren(c_wren_a),
        .busy(busy_a), .done(done_a)
    );

    rc4_encryptor #(.MSG_LEN(256)) dut_b (
        .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
        .s_address(s_address_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
        .p_address(p_address_b), .p_q(p_q_b),
        .c_address(c_address_b), .c_data(c_data_b), .c_wren(c_wren_b),
        .busy(busy_b), .done(done_b)
    );

    logic [7:0] s_a [256], c_a [256], p_a [256];
    logic [7:0] s_b [256], c_b [256], p_b [256];
    logic [7:0] sa_a, pa_a, sa_b, pa_b;
    int cw_a, cw_b, ov, act;

    always @(posedge clk) begin
        sa_a <= s_address_a;
        s_q_a <= s_a[sa_a];
        pa_a <= p_address_a;
        p_q_a <= p_a[pa_a];
        sa_b <= s_address_b;
        s_q_b <= s_b[sa_b];
        pa_b <= p_address_b;
        p_q_b <= p_b[pa_b];
        if (s_wren_a) s_a[s_address_a] <= s_data_a;
        if (s_wren_b) s_b[s_address_b] <= s_data_b;
        if (c_wren_a) c_a[c_address_a] <= c_data_a;
        if (c_wren_b) c_b[c_address_b] <= c_data_b;
        if (clr) for (int x = 0; x < 256; x++) begin
            c_a[x] <= 8'h00;
            c_b[x] <= 8'h00;
        end
        cw_a <= cw_a + int'(c_wren_a);
        cw_b <= cw_b + int'(c_wren_b);
        ov <= ov + int'((s_wren_a && c_wren_a) || (s_wren_b && c_wren_b));
        act <= act + int'(s_wren_a || c_wren_a || busy_a || s_wren_b || c_wren_b || busy_b);
    end

    typedef struct {
        logic [7:0] pt;
        logic [7:0] ct;
    } vec_t;

    vec_t kat [9];
    logic [7:0] exp_s [256], exp_c [256], snap [256], pt_b [256];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic rc4_model(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] mi, mj, t;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        mj = 8'h00;
        for (int x = 0; x < 256; x++) begin
            mj = mj + s[x] + key[23 - 8 * (x % 3) -: 8];
            t = s[x];
            s[x] = s[mj];
            s[mj] = t;
        end
        for (int x = 0; x < 256; x++) exp_s[x] = s[x];
        mi = 8'h00;
        mj = 8'h00;
        for (int x = 0; x < 256; x++) begin
            mi = mi + 8'h01;
            mj = mj + s[mi];
            t = s[mi];
            s[mi] = s[mj];
            s[mj] = t;
            t = s[mi] + s[mj];
            exp_c[x] = s[t] ^ p_b[x];
        end
    endtask

    task automatic clear_c();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic run(input logic [23:0] key, input int pulse_at,
                       output int na, output int nb, output logic d1, output logic b1);
        secret_key = key;
        start = 1'b1;
        na = 0;
        nb = 0;
        d1 = 1'bx;
        b1 = 1'bx;
        for (int n = 1; n <= 6000 && (na == 0 || nb == 0); n++) begin
            @(posedge clk);
            #1;
            start = (n == pulse_at);
            if (n == 1) begin
                d1 = done_a;
                b1 = busy_a;
            end
            if (n == 2305) for (int x = 0; x < 256; x++) snap[x] = s_b[x];
            if (done_a && na == 0) na = n;
            if (done_b && nb == 0) nb = n;
        end
        start = 1'b0;
    endtask

    task automatic check_kat(input string tag);
        for (int x = 0; x < 9; x++) chk($sformatf("%s_c%0d", tag, x), 64'(c_a[x]), 64'(kat[x].ct));
    endtask

    task automatic check_b(input string tag);
        int bad = 0;
        for (int x = 0; x < 256; x++) if (c_b[x] !== exp_c[x]) bad++;
        chk(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        int na, nb, w0, wb0, a0, bad;
        logic d1, b1;
        kat[0] = '{8'h50, 8'hBB};
        kat[1] = '{8'h6C, 8'hF3};
        kat[2] = '{8'h61, 8'h16};
        kat[3] = '{8'h69, 8'hE8};
        kat[4] = '{8'h6E, 8'hD9};
        kat[5] = '{8'h74, 8'h40};
        kat[6] = '{8'h65, 8'hAF};
        kat[7] = '{8'h78, 8'h0A};
        kat[8] = '{8'h74, 8'hD3};
        for (int x = 0; x < 256; x++) begin
            p_a[x] = (x < 9) ? kat[x].pt : 8'h00;
            pt_b[x] = 8'(x * 7 + 3);
            p_b[x] = pt_b[x];
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_a", 64'({s_address_a, s_data_a, s_wren_a, p_address_a, c_address_a, c_data_a, c_wren_a, busy_a, done_a}), 64'd0);
        chk("reset_outputs_b", 64'({s_address_b, s_data_b, s_wren_b, p_address_b, c_address_b, c_data_b, c_wren_b, busy_b, done_b}), 64'd0);
        reset = 1'b1;
        a0 = act;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_activity", 64'(act - a0), 64'd0);

        clear_c();
        w0 = cw_a;
        wb0 = cw_b;
        run(24'h4B6579, 0, na, nb, d1, b1);
        chk("kat_done_cycles", 64'(na), 64'd2413);
        chk("b_done_cycles", 64'(nb), 64'd5377);
        chk("start_busy", 64'(b1), 64'd1);
        check_kat("kat");
        chk("kat_write_count", 64'(cw_a - w0), 64'd9);
        chk("b_write_count", 64'(cw_b - wb0), 64'd256);
        rc4_model(24'h4B6579);
        check_b("b_kat_bytes");

        clear_c();
        wb0 = cw_b;
        rc4_model(24'h000000);
        run(24'h000000, 0, na, nb, d1, b1);
        chk("restart_done_low", 64'(d1), 64'd0);
        chk("restart_busy_high", 64'(b1), 64'd1);
        bad = 0;
        for (int x = 0; x < 256; x++) if (snap[x] !== exp_s[x]) bad++;
        chk("key0_ksa_s_mismatches", 64'(bad), 64'd0);
        check_b("key0_c_mismatches");
        chk("key0_write_count", 64'(cw_b - wb0), 64'd256);

        clear_c();
        rc4_model(24'h000249);
        run(24'h000249, 0, na, nb, d1, b1);
        check_b("rt_encrypt_mismatches");
        for (int x = 0; x < 256; x++) p_b[x] = c_b[x];
        clear_c();
        run(24'h000249, 0, na, nb, d1, b1);
        bad = 0;
        for (int x = 0; x < 256; x++) if (c_b[x] !== pt_b[x]) bad++;
        chk("rt_decrypt_mismatches", 64'(bad), 64'd0);
        for (int x = 0; x < 256; x++) p_b[x] = pt_b[x];

        secret_key = 24'h4B6579;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (1255) @(posedge clk);
        #1;
        chk("midrun_busy_before", 64'(busy_a), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_reset_a", 64'({s_wren_a, c_wren_a, busy_a, done_a, s_address_a}), 64'd0);
        chk("midrun_reset_b", 64'({s_wren_b, c_wren_b, busy_b, done_b, s_address_b}), 64'd0);
        reset = 1'b1;
        clear_c();
        run(24'h4B6579, 0, na, nb, d1, b1);
        chk("rerun_done_cycles", 64'(na), 64'd2413);
        check_kat("rerun");

        clear_c();
        rc4_model(24'h4B6579);
        run(24'h4B6579, 2330, na, nb, d1, b1);
        chk("prga_pulse_done_cycles", 64'(na), 64'd2413);
        chk("prga_pulse_b_done_cycles", 64'(nb), 64'd5377);
        check_kat("prga_pulse");
        check_b("prga_pulse_b_mismatches");

        chk("wren_overlap", 64'(ov), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rc4_encryptor.md
Name: rc4_encryptor

Overview:
- Generates the ciphertext image that the key-search datapath reads back, so it acts as the writer counterpart of the decrypt/crack path.
- Performs RC4 KSA and PRGA with a 24-bit key over a shared 256x8 S memory.
- XORs the keystream with bytes read from a plaintext ROM and writes the results into a ciphertext RAM.
- Enables on-board generation of test messages for arbitrary keys.

Parameters:
- MSG_LEN, 32, number of message bytes processed (1..256).
- KEY_BYTES, 3, key length in bytes; key byte n = secret_key[23-8n -: 8], so byte0 is secret_key[23:16].

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-low reset; reset=0 at a rising edge resets the block.
- start  in  1  one-cycle request; sampled only in IDLE.
- secret_key  in  24  RC4 key; latched on an accepted start.
- s_address  out  8  S memory address.
- s_data  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- s_q  in  8  S memory read data.
- p_address  out  8  plaintext ROM address.
- p_q  in  8  plaintext ROM data.
- c_address  out  8  ciphertext RAM address.
- c_data  out  8  ciphertext RAM write data.
- c_wren  out  1  ciphertext RAM write enable.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  level; high in DONE until the next accepted start or reset.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, i, j and k are cleared. Reset mid-run aborts immediately; wren signals are low from the next cycle and no partial write occurs after reset.
- Memory timing: every read drives the address in state RD_x and holds it through WT_x. Data is captured from s_q or p_q in the following state, i.e. two cycles after the address is first driven.
- IDLE:
  - start=1 latches the key, sets done=0 and busy=1, then moves to INIT.
  - start while busy is ignored.
- INIT: writes S[i]=i for i=0..255, one write per cycle with s_wren=1. Exactly 256 cycles, then KSA with i=0 and j=0.
- KSA, 8 cycles per i, for i=0..255:
  - RD_I, WT_I
  - LD_I: si=s_q; j = j+si+key[i mod KEY_BYTES], mod 256.
  - RD_J, WT_J
  - LD_J: sj=s_q.
  - WR_I: S[i]=sj.
  - WR_J: S[j]=si.
  - Wraps to PRGA after i=255, clearing i, j and k.
- i==j: both writes carry the same value, and the final S[i] must equal the original value.
- PRGA, for k=0..MSG_LEN-1:
  - INC: i=i+1.
  - RD_I, WT_I
  - LD_I: si=s_q; j=j+si.
  - RD_J, WT_J
  - LD_J: sj=s_q.
  - WR_I: S[i]=sj.
  - WR_J: S[j]=si.
  - RD_F: s_address=si+sj mod 256; p_address=k.
  - WT_F
  - WR_C: c_address=k; c_data=s_q XOR p_q; c_wren=1 for exactly one cycle.
  - After WR_C, k increments. When k==MSG_LEN-1, go to DONE.
- All 8-bit arithmetic wraps mod 256. k never exceeds MSG_LEN-1. MSG_LEN=256 writes addresses 0..255 with no extra write.
- DONE: busy=0, done=1, all wren low. start=1 starts a new run and clears done the following cycle.
- No S or C write occurs outside INIT, WR_I, WR_J and WR_C. s_wren and c_wren are never high in the same cycle.
- Total run length is fixed: 256 + 2048 + 12*MSG_LEN cycles plus 1 cycle for the IDLE to INIT transition.

Test Plan:
- Reset then idle → all outputs 0; 100 cycles with start=0 → no wren pulses and busy=0.
- Known-answer test: MSG_LEN=9, secret_key=24'h4B6579 ("Key"), plaintext "Plaintext" → C RAM holds BB F3 16 E8 D9 40 AF 0A D3. done rises exactly 256+2048+108+1 cycles after start.
- i==j and wrap: secret_key=24'h000000 → S memory after KSA matches a software model byte-for-byte. PRGA i wraps 255→0 with MSG_LEN=256, and all 256 C bytes match the model.
- Round trip: secret_key=24'h000249, 32-byte plaintext → load C RAM into the existing decrypt path with the same key; decrypted RAM equals the plaintext.
- Reset mid-run: assert reset=0 in KSA cycle 1000 → next cycle s_wren=0, busy=0, state IDLE. A new start then reproduces the known-answer test result.
- start pulsed during PRGA → ignored, output identical to an undisturbed run. start pulsed in DONE → done=0 the next cycle and a full second run completes correctly.
